ones_search_scheduler: RTL and testbench

Shares one iterative find-all-ones search engine (priority-encoder based, one '1' per cycle) between R requesters. Each requester offers an N-bit vector through a valid/ready handshake. Requesters are granted round-robin. The block pulses the engine start, waits for its done pulse, then streams the found bit positions one per beat on a backpressured output tagged with the requester id. It sits between the energy-monitor clients and the shared search engine.

---
 rtl/ones_search_scheduler.sv | 249 ++++++++++++++++++++++++
 tb/tb_ones_search_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ones_search_scheduler.sv
// ---------------------------------------------------------------------------
// ones_search_scheduler
//
// Shares one iterative find-all-ones search engine between R requesters.
// Requesters are picked round-robin from IDLE. The accepted vector is latched
// and driven to the engine, which is then started with a one-cycle pulse.
// When the engine reports done, the found positions are streamed one per beat
// on a valid/ready output tagged with the requester id. A vector with no '1'
// bits produces a single "empty" beat. An engine that never answers produces
// a single "error" beat after TIMEOUT cycles in WAIT.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_valid_i[R]     requester r has a vector pending
//   req_data_i[R][N]   vector per requester
//   req_ready_o[R]     one-hot accept to the granted requester (combinational)
//   eng_start_o        one-cycle engine start pulse
//   eng_data_o[N]      latched vector driven to the engine
//   eng_positions_i    engine position array (N x LOGN), held after done
//   eng_count_i        engine found count (LOGN+1 bits)
//   eng_done_i         engine done pulse
//   eng_empty_i        engine empty flag
//   out_valid_o/out_ready_i  result beat handshake
//   out_pos_o          bit position of this beat
//   out_id_o           requester id of the current job
//   out_last_o         final beat of the job
//   out_empty_o        job had no '1' bits (single beat)
//   out_err_o          watchdog abort (single beat)
//   busy_o             scheduler is not idle
// ---------------------------------------------------------------------------
module ones_search_scheduler #(
   parameter int unsigned N       = 256,
   parameter int unsigned LOGN    = (N > 1) ? $clog2(N) : 1,
   parameter int unsigned R       = 4,
   parameter int unsigned IDW     = (R > 1) ? $clog2(R) : 1,
   parameter int unsigned TIMEOUT = N + 8,
   parameter int unsigned TW      = $clog2(TIMEOUT + 1)
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [R-1:0]               req_valid_i,
   input  logic [R-1:0][N-1:0]        req_data_i,
   output logic [R-1:0]               req_ready_o,
   output logic                       eng_start_o,
   output logic [N-1:0]               eng_data_o,
   input  logic [N-1:0][LOGN-1:0]     eng_positions_i,
   input  logic [LOGN:0]              eng_count_i,
   input  logic                       eng_done_i,
   input  logic                       eng_empty_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [LOGN-1:0]            out_pos_o,
   output logic [IDW-1:0]             out_id_o,
   output logic                       out_last_o,
   output logic                       out_empty_o,
   output logic                       out_err_o,
   output logic                       busy_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_WAIT   = 3'd2,
      S_STREAM = 3'd3,
      S_EMPTY  = 3'd4,
      S_ERR    = 3'd5
   } state_e;

   state_e           state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [LOGN:0]    idx_q, idx_d;
   logic [TW-1:0]    wdog_q, wdog_d;
   logic [N-1:0]     data_q, data_d;
   logic [IDW-1:0]   id_q, id_d;

   logic             grant_found_s;
   logic [IDW-1:0]   grant_id_s;
   logic [IDW:0]     cand_s;
   logic             last_s;
   logic [TW-1:0]    wdog_inc_s;

   // Successor of a requester id, wrapping at R-1 (also correct for R==1).
   function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
      if (id == IDW'(R - 1)) begin
         return '0;
      end else begin
         return id + IDW'(1'b1);
      end
   endfunction

   // idx is one bit wider than a position, so idx+1 reaches N without wrapping.
   assign last_s     = ((idx_q + (LOGN+1)'(1'b1)) == eng_count_i);
   assign wdog_inc_s = wdog_q + TW'(1'b1);
   assign eng_data_o = data_q;
   assign busy_o     = (state_q != S_IDLE);

   // Round-robin search starting at rr_ptr; the first valid requester wins.
   always_comb begin
      grant_found_s = 1'b0;
      grant_id_s    = '0;
      cand_s        = '0;
      for (int i = 0; i < R; i++) begin
         cand_s = {1'b0, rr_ptr_q} + (IDW+1)'(i);
         if (cand_s >= (IDW+1)'(R)) begin
            cand_s = cand_s - (IDW+1)'(R);
         end else begin
            cand_s = cand_s;
         end
         if (!grant_found_s && req_valid_i[cand_s[IDW-1:0]]) begin
            grant_found_s = 1'b1;
            grant_id_s    = cand_s[IDW-1:0];
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   // Next-state and datapath update logic.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      idx_d    = idx_q;
      wdog_d   = wdog_q;
      data_d   = data_q;
      id_d     = id_q;
      case (state_q)
         S_IDLE: begin
            if (grant_found_s) begin
               data_d  = req_data_i[grant_id_s];
               id_d    = grant_id_s;
               state_d = S_LAUNCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LAUNCH: begin
            wdog_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            wdog_d = wdog_inc_s;
            // A done arriving on the timeout cycle still wins.
            if (eng_done_i) begin
               idx_d = '0;
               if ((eng_count_i == '0) || eng_empty_i) begin
                  state_d = S_EMPTY;
               end else begin
                  state_d = S_STREAM;
               end
            end else if (wdog_inc_s == TW'(TIMEOUT)) begin
               state_d = S_ERR;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_STREAM: begin
            if (out_ready_i) begin
               if (last_s) begin
                  rr_ptr_d = next_id(id_q);
                  state_d  = S_IDLE;
               end else begin
                  idx_d = idx_q + (LOGN+1)'(1'b1);
               end
            end else begin
               state_d = S_STREAM;
            end
         end
         S_EMPTY, S_ERR: begin
            if (out_ready_i) begin
               rr_ptr_d = next_id(id_q);
               state_d  = S_IDLE;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode; ready is gated by reset so every output is 0 while in reset.
   always_comb begin
      req_ready_o = '0;
      eng_start_o = 1'b0;
      out_valid_o = 1'b0;
      out_pos_o   = '0;
      out_id_o    = '0;
      out_last_o  = 1'b0;
      out_empty_o = 1'b0;
      out_err_o   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (grant_found_s && rst_ni) begin
               req_ready_o[grant_id_s] = 1'b1;
            end else begin
               req_ready_o = '0;
            end
         end
         S_LAUNCH: begin
            eng_start_o = 1'b1;
         end
         S_WAIT: begin
            eng_start_o = 1'b0;
         end
         S_STREAM: begin
            out_valid_o = 1'b1;
            out_pos_o   = eng_positions_i[idx_q[LOGN-1:0]];
            out_id_o    = id_q;
            out_last_o  = last_s;
         end
         S_EMPTY: begin
            out_valid_o = 1'b1;
            out_id_o    = id_q;
            out_last_o  = 1'b1;
            out_empty_o = 1'b1;
         end
         S_ERR: begin
            out_valid_o = 1'b1;
            out_id_o    = id_q;
            out_last_o  = 1'b1;
            out_err_o   = 1'b1;
         end
         default: begin
            out_valid_o = 1'b0;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         idx_q    <= '0;
         wdog_q   <= '0;
         data_q   <= '0;
         id_q     <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         idx_q    <= idx_d;
         wdog_q   <= wdog_d;
         data_q   <= data_d;
         id_q     <= id_d;
      end
   end

endmodule

// File: tb/tb_ones_search_scheduler.sv
module tb_ones_search_scheduler;

   localparam int N       = 16;
   localparam int LOGN    = 4;
   localparam int R       = 2;
   localparam int IDW     = 1;
   localparam int TIMEOUT = 24;

   logic                   clk_i = 1'b0;
   logic                   rst_ni = 1'b1;
   logic [R-1:0]           req_valid;
   logic [R-1:0][N-1:0]    req_data;
   logic [R-1:0]           req_ready_o;
   logic                   eng_start_o;
   logic [N-1:0]           eng_data_o;
   logic [N-1:0][LOGN-1:0] eng_pos;
   logic [LOGN:0]          eng_count;
   logic                   eng_done;
   logic                   eng_empty;
   logic                   out_valid_o;
   logic                   out_ready;
   logic [LOGN-1:0]        out_pos_o;
   logic [IDW-1:0]         out_id_o;
   logic                   out_last_o;
   logic                   out_empty_o;
   logic                   out_err_o;
   logic                   busy_o;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_pos[$];
   int eng_dly;
   bit eng_hang = 1'b0;

   ones_search_scheduler #(
      .N(N), .LOGN(LOGN), .R(R), .IDW(IDW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready_o),
      .eng_start_o(eng_start_o), .eng_data_o(eng_data_o),
      .eng_positions_i(eng_pos), .eng_count_i(eng_count),
      .eng_done_i(eng_done), .eng_empty_i(eng_empty),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready),
      .out_pos_o(out_pos_o), .out_id_o(out_id_o), .out_last_o(out_last_o),
      .out_empty_o(out_empty_o), .out_err_o(out_err_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Ascending list of set-bit positions, packed LOGN bits per entry.
   function automatic logic [N*LOGN-1:0] find_pos(input logic [N-1:0] v);
      logic [N-1:0][LOGN-1:0] p;
      int k;
      p = '0;
      k = 0;
      for (int i = 0; i < N; i++) begin
         if (v[i]) begin
            p[k] = LOGN'(i);
            k++;
         end
      end
      return p;
   endfunction

   // Engine model: done pulse 3 cycles after start, results held until the next start.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         eng_dly   <= 0;
         eng_done  <= 1'b0;
         eng_pos   <= '0;
         eng_count <= '0;
         eng_empty <= 1'b0;
      end else begin
         eng_done <= 1'b0;
         if (eng_start_o) begin
            eng_dly   <= 3;
            eng_pos   <= find_pos(eng_data_o);
            eng_count <= (LOGN+1)'($countones(eng_data_o));
            eng_empty <= (eng_data_o == 16'h0000);
         end else if (eng_dly > 0) begin
            eng_dly <= eng_dly - 1;
            if (eng_dly == 1 && !eng_hang) eng_done <= 1'b1;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_ni    = 1'b0;
      req_valid = '0;
      req_data  = '0;
      out_ready = 1'b0;
      #1;
      check_eq("rst_out_valid", 32'(out_valid_o), 32'd0);
      check_eq("rst_busy", 32'(busy_o), 32'd0);
      check_eq("rst_start", 32'(eng_start_o), 32'd0);
      check_eq("rst_eng_data", 32'(eng_data_o), 32'd0);
      check_eq("rst_ready", 32'(req_ready_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic offer(input int r, input logic [N-1:0] v, input logic [R-1:0] exp_rdy);
      @(negedge clk_i);
      req_valid[r] = 1'b1;
      req_data[r]  = v;
      #1;
      check_eq("req_ready", 32'(req_ready_o), 32'(exp_rdy));
   endtask

   // Consume beats; kind 0 = positions, 1 = empty, 2 = error.
   task automatic collect(input int nconsume, input int ntotal, input int id,
                          input int kind, input bit toggle);
      int beat;
      int cyc;
      beat = 0;
      cyc  = 0;
      while (beat < nconsume && cyc < 200) begin
         @(negedge clk_i);
         out_ready = toggle ? ((cyc % 3) == 0) : 1'b1;
         #1;
         if (out_valid_o) begin
            check_eq("pos", 32'(out_pos_o), 32'(exp_pos[beat]));
            check_eq("id", 32'(out_id_o), 32'(id));
            check_eq("last", 32'(out_last_o), 32'(beat == ntotal - 1));
            check_eq("empty", 32'(out_empty_o), 32'(kind == 1));
            check_eq("err", 32'(out_err_o), 32'(kind == 2));
            if (out_ready) beat++;
         end
         cyc++;
      end
      check_eq("beat_count", 32'(beat), 32'(nconsume));
   endtask

   task automatic post_idle();
      @(negedge clk_i);
      out_ready = 1'b0;
      #1;
      check_eq("post_busy", 32'(busy_o), 32'd0);
      check_eq("post_valid", 32'(out_valid_o), 32'd0);
   endtask

   initial begin
      int k;
      bit found;
      req_valid = '0;
      req_data  = '0;
      out_ready = 1'b0;
      do_reset();

      // 1: 0x00A5 from requester 0 -> positions 0,2,5,7
      offer(0, 16'h00A5, 2'b01);
      @(negedge clk_i);
      req_valid[0] = 1'b0;
      #1;
      check_eq("t1_start", 32'(eng_start_o), 32'd1);
      check_eq("t1_eng_data", 32'(eng_data_o), 32'h00A5);
      check_eq("t1_busy", 32'(busy_o), 32'd1);
      @(negedge clk_i);
      #1;
      check_eq("t1_start_off", 32'(eng_start_o), 32'd0);
      exp_pos = '{0, 2, 5, 7};
      collect(4, 4, 0, 0, 1'b0);
      post_idle();

      // 2: empty vector from requester 1
      offer(1, 16'h0000, 2'b10);
      @(negedge clk_i);
      req_valid[1] = 1'b0;
      exp_pos = '{0};
      collect(1, 1, 1, 1, 1'b0);
      post_idle();

      // 3: both valid right after reset -> 0, 1, then 0 again
      do_reset();
      @(negedge clk_i);
      req_valid   = 2'b11;
      req_data[0] = 16'h0001;
      req_data[1] = 16'h8000;
      #1;
      check_eq("t3_first_grant", 32'(req_ready_o), 32'h1);
      exp_pos = '{0};
      collect(1, 1, 0, 0, 1'b0);
      @(negedge clk_i);
      #1;
      check_eq("t3_idle", 32'(busy_o), 32'd0);
      check_eq("t3_second_grant", 32'(req_ready_o), 32'h2);
      exp_pos = '{15};
      collect(1, 1, 1, 0, 1'b0);
      @(negedge clk_i);
      #1;
      check_eq("t3_third_grant", 32'(req_ready_o), 32'h1);
      req_valid = '0;

      // 4: 0xFFFF with stalling consumer
      offer(0, 16'hFFFF, 2'b01);
      @(negedge clk_i);
      req_valid[0] = 1'b0;
      exp_pos.delete();
      for (int i = 0; i < 16; i++) exp_pos.push_back(i);
      collect(16, 16, 0, 0, 1'b1);
      post_idle();

      // 5: engine never answers -> error beat after TIMEOUT WAIT cycles
      eng_hang = 1'b1;
      offer(1, 16'h0003, 2'b10);
      @(negedge clk_i);
      req_valid[1] = 1'b0;
      #1;
      check_eq("t5_start", 32'(eng_start_o), 32'd1);
      k = 0;
      found = 1'b0;
      while (!found && k < 60) begin
         @(negedge clk_i);
         #1;
         k++;
         if (out_valid_o) found = 1'b1;
      end
      check_eq("t5_err_latency", 32'(k), 32'd25);
      check_eq("t5_err", 32'(out_err_o), 32'd1);
      check_eq("t5_last", 32'(out_last_o), 32'd1);
      check_eq("t5_pos", 32'(out_pos_o), 32'd0);
      check_eq("t5_empty", 32'(out_empty_o), 32'd0);
      check_eq("t5_id", 32'(out_id_o), 32'd1);
      out_ready = 1'b1;
      post_idle();
      eng_hang = 1'b0;
      @(negedge clk_i);
      req_valid = 2'b11;
      #1;
      check_eq("t5_rr_after_err", 32'(req_ready_o), 32'h1);
      req_valid = '0;

      // 6: reset while the pos-5 beat of 0x00A5 is pending
      offer(0, 16'h00A5, 2'b01);
      @(negedge clk_i);
      req_valid[0] = 1'b0;
      exp_pos = '{0, 2, 5, 7};
      collect(2, 4, 0, 0, 1'b0);
      @(negedge clk_i);
      out_ready = 1'b0;
      #1;
      check_eq("t6_valid_before", 32'(out_valid_o), 32'd1);
      check_eq("t6_pos_before", 32'(out_pos_o), 32'd5);
      rst_ni = 1'b0;
      #1;
      check_eq("t6_valid_rst", 32'(out_valid_o), 32'd0);
      check_eq("t6_busy_rst", 32'(busy_o), 32'd0);
      @(negedge clk_i);
      #1;
      check_eq("t6_valid_next", 32'(out_valid_o), 32'd0);
      check_eq("t6_busy_next", 32'(busy_o), 32'd0);
      rst_ni = 1'b1;
      offer(1, 16'h0010, 2'b10);
      @(negedge clk_i);
      req_valid[1] = 1'b0;
      exp_pos = '{4};
      collect(1, 1, 1, 0, 1'b0);
      post_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1);
   end

endmodule
